// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - per-tick clear/move/draw handshake sequencer
// Runs one update sequence per rising edge of rclock, with ack timeouts and sticky error flags.
module tick_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rclock,
  output logic        clear,
  output logic        move_req,
  input  logic        move_ack,
  output logic        draw_req,
  input  logic        draw_ack,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MOVE  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] WAIT_LAST = TIMEOUT - 16'd1;

  state_t      r_state;
  logic        r_rclock;
  logic        r_armed;
  logic [15:0] r_wait;
  logic        r_clear;
  logic        r_move_req;
  logic        r_draw_req;
  logic        r_busy;
  logic        r_overrun;
  logic        r_timeout_err;
  logic [15:0] r_frame_count;
  logic        w_tick;

  // r_armed blocks a tick from an rclock that was already high when reset released.
  assign w_tick = rclock & ~r_rclock & r_armed;

  assign clear       = r_clear;
  assign move_req    = r_move_req;
  assign draw_req    = r_draw_req;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign frame_count = r_frame_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rclock      <= 1'b0;
      r_armed       <= 1'b0;
      r_wait        <= 16'd0;
      r_clear       <= 1'b0;
      r_move_req    <= 1'b0;
      r_draw_req    <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_rclock <= rclock;
      r_armed  <= r_armed | ~rclock;
      r_clear  <= 1'b0;
      if (w_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_CLEAR;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state    <= ST_MOVE;
          r_move_req <= 1'b1;
          r_wait     <= 16'd0;
        end
        ST_MOVE: begin
          if (move_ack) begin
            r_state    <= ST_DRAW;
            r_move_req <= 1'b0;
            r_draw_req <= 1'b1;
            r_wait     <= 16'd0;
          end else if (r_wait == WAIT_LAST) begin
            r_state       <= ST_IDLE;
            r_move_req    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        ST_DRAW: begin
          if (draw_ack) begin
            r_state    <= ST_DONE;
            r_draw_req <= 1'b0;
          end else if (r_wait == WAIT_LAST) begin
            r_state       <= ST_IDLE;
            r_draw_req    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        ST_DONE: begin
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_frame_count <= r_frame_count + 16'd1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_move_req <= 1'b0;
          r_draw_req <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// tb/tb_tick_sequencer.sv - directed self-checking bench for tick_sequencer
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_tick_sequencer;

  logic        clock;
  logic        reset;
  logic        rclock;
  logic        clear;
  logic        move_req;
  logic        move_ack;
  logic        draw_req;
  logic        draw_ack;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] frame_count;

  int n_assert;
  int n_fail;

  tick_sequencer #(.TIMEOUT(16'd8)) dut (
    .clock       (clock),
    .reset       (reset),
    .rclock      (rclock),
    .clear       (clear),
    .move_req    (move_req),
    .move_ack    (move_ack),
    .draw_req    (draw_req),
    .draw_ack    (draw_ack),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clear"}, {15'd0, clear}, 16'd0);
    check({tag, "_move_req"}, {15'd0, move_req}, 16'd0);
    check({tag, "_draw_req"}, {15'd0, draw_req}, 16'd0);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_overrun"}, {15'd0, overrun}, 16'd0);
    check({tag, "_timeout_err"}, {15'd0, timeout_err}, 16'd0);
    check({tag, "_frame_count"}, frame_count, 16'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rclock   = 1'b0;
    move_ack = 1'b0;
    draw_ack = 1'b0;
    #12;
    check_all_zero("reset");
    step();
    reset = 1'b0;
    step();
    step();

    // Nominal sequence: move_ack 3 cycles after move_req, draw_ack 5 after draw_req
    rclock = 1'b1;
    step();
    check("a_clear_lat", {15'd0, clear}, 16'd1);
    check("a_move_not_yet", {15'd0, move_req}, 16'd0);
    check("a_busy", {15'd0, busy}, 16'd1);
    rclock = 1'b0;
    step();
    check("a_move_req_rise", {15'd0, move_req}, 16'd1);
    check("a_clear_one_cycle", {15'd0, clear}, 16'd0);
    step();
    step();
    check("a_move_req_hold", {15'd0, move_req}, 16'd1);
    step();
    move_ack = 1'b1;
    step();
    check("a_move_req_drop", {15'd0, move_req}, 16'd0);
    check("a_draw_req_rise", {15'd0, draw_req}, 16'd1);
    move_ack = 1'b0;
    repeat (5) step();
    check("a_draw_req_hold", {15'd0, draw_req}, 16'd1);
    check("a_no_both_req", {15'd0, move_req}, 16'd0);
    draw_ack = 1'b1;
    step();
    check("a_draw_req_drop", {15'd0, draw_req}, 16'd0);
    check("a_busy_done", {15'd0, busy}, 16'd1);
    check("a_fc_before_done", frame_count, 16'd0);
    draw_ack = 1'b0;
    step();
    check("a_fc", frame_count, 16'd1);
    check("a_busy_idle", {15'd0, busy}, 16'd0);

    // move_ack already high before the sequence starts
    move_ack = 1'b1;
    step();
    rclock = 1'b1;
    step();
    check("b_clear", {15'd0, clear}, 16'd1);
    check("b_move_ignored_ack", {15'd0, move_req}, 16'd0);
    rclock = 1'b0;
    step();
    check("b_move_req_1cyc", {15'd0, move_req}, 16'd1);
    step();
    check("b_move_req_drop", {15'd0, move_req}, 16'd0);
    check("b_draw_req", {15'd0, draw_req}, 16'd1);
    move_ack = 1'b0;
    draw_ack = 1'b1;
    step();
    check("b_draw_req_drop", {15'd0, draw_req}, 16'd0);
    draw_ack = 1'b0;
    step();
    check("b_fc", frame_count, 16'd2);
    check("b_busy", {15'd0, busy}, 16'd0);

    // Second tick while draw_req pending
    check("c_overrun_pre", {15'd0, overrun}, 16'd0);
    rclock = 1'b1;
    step();
    rclock = 1'b0;
    step();
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    check("c_draw_req", {15'd0, draw_req}, 16'd1);
    rclock = 1'b1;
    step();
    check("c_overrun", {15'd0, overrun}, 16'd1);
    check("c_draw_req_still", {15'd0, draw_req}, 16'd1);
    rclock = 1'b0;
    step();
    draw_ack = 1'b1;
    step();
    draw_ack = 1'b0;
    step();
    check("c_fc", frame_count, 16'd3);
    repeat (3) step();
    check("c_no_queued_busy", {15'd0, busy}, 16'd0);
    check("c_no_queued_clear", {15'd0, clear}, 16'd0);
    check("c_fc_stable", frame_count, 16'd3);

    // Timeout with move_ack held low, TIMEOUT = 8
    rclock = 1'b1;
    step();
    rclock = 1'b0;
    step();
    check("d_move_req", {15'd0, move_req}, 16'd1);
    repeat (7) step();
    check("d_move_req_8th", {15'd0, move_req}, 16'd1);
    check("d_terr_pre", {15'd0, timeout_err}, 16'd0);
    step();
    check("d_move_req_drop", {15'd0, move_req}, 16'd0);
    check("d_terr", {15'd0, timeout_err}, 16'd1);
    check("d_busy", {15'd0, busy}, 16'd0);
    check("d_fc", frame_count, 16'd3);
    step();
    check("d_no_draw", {15'd0, draw_req}, 16'd0);
    check("d_idle", {15'd0, busy}, 16'd0);

    // frame_count wrap
    force dut.r_frame_count = 16'hFFFF;
    step();
    release dut.r_frame_count;
    check("e_fc_preload", frame_count, 16'hFFFF);
    move_ack = 1'b1;
    draw_ack = 1'b1;
    rclock = 1'b1;
    step();
    rclock = 1'b0;
    repeat (4) step();
    check("e_fc_wrap", frame_count, 16'd0);
    check("e_busy", {15'd0, busy}, 16'd0);
    move_ack = 1'b0;
    draw_ack = 1'b0;

    // Reset while draw_req high with rclock high
    rclock = 1'b1;
    step();
    step();
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    check("f_draw_req_pre", {15'd0, draw_req}, 16'd1);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("f_async_reset");
    step();
    reset = 1'b0;
    repeat (3) step();
    check("f_no_tick_busy", {15'd0, busy}, 16'd0);
    check("f_no_tick_clear", {15'd0, clear}, 16'd0);
    rclock = 1'b0;
    step();
    rclock = 1'b1;
    step();
    check("f_rearm_clear", {15'd0, clear}, 16'd1);

    // Tick landing in the DONE cycle counts as overrun
    move_ack = 1'b1;
    draw_ack = 1'b1;
    rclock = 1'b0;
    step();
    step();
    step();
    check("g_busy_done", {15'd0, busy}, 16'd1);
    check("g_overrun_pre", {15'd0, overrun}, 16'd0);
    rclock = 1'b1;
    step();
    check("g_overrun", {15'd0, overrun}, 16'd1);
    check("g_fc", frame_count, 16'd1);
    repeat (3) step();
    check("g_no_seq", {15'd0, busy}, 16'd0);
    move_ack = 1'b0;
    draw_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd1000, meaning the maximum number of clock cycles to wait for any acknowledge.
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rclock  input  1  slow game-tick level from the refresh divider, synchronous to clock.
REQ-005 SHALL have port clear  output  1  one-cycle frame-clear strobe to the display/board logic.
REQ-006 SHALL have port move_req  output  1  request to the snake logic to advance one step.
REQ-007 SHALL have port move_ack  input  1  snake logic has completed its step.
REQ-008 SHALL have port draw_req  output  1  request to the renderer to redraw the board.
REQ-009 SHALL have port draw_ack  input  1  renderer has completed the redraw.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port overrun  output  1  sticky flag: a tick arrived while busy.
REQ-012 SHALL have port timeout_err  output  1  sticky flag: an acknowledge did not arrive within TIMEOUT cycles.
REQ-013 SHALL have port frame_count  output  16  count of completed update sequences.

Function
REQ-014 SHALL register rclock once and detect a tick as rclock high while the registered copy is low, i.e. a rising edge.
REQ-015 SHALL implement the states IDLE, CLEAR, MOVE, DRAW and DONE.
REQ-016 IDLE: on a tick SHALL go to CLEAR; otherwise SHALL stay in IDLE.
REQ-017 CLEAR: SHALL assert clear for exactly one cycle, then go to MOVE.
REQ-018 MOVE: SHALL hold move_req high until the first cycle move_ack is sampled high, then deassert move_req the next cycle and go to DRAW.
REQ-019 DRAW: SHALL behave as MOVE, using draw_req/draw_ack, then go to DONE.
REQ-020 DONE: SHALL increment frame_count by 1, wrapping from 16'hFFFF to 0, and return to IDLE after one cycle.
REQ-021 Tick-to-clear latency SHALL be 1 cycle: clear is high in the cycle after the edge is detected.
REQ-022 move_req SHALL rise in the cycle after clear is high.
REQ-023 An ack arriving while its req is low SHALL be ignored.
REQ-024 An ack that is already high on the first req cycle SHALL be accepted.
REQ-025 A 16-bit wait counter SHALL clear on entry to MOVE and on entry to DRAW, and SHALL increment each cycle the sequencer waits.
REQ-026 If the wait counter reaches TIMEOUT in MOVE or DRAW, the sequencer SHALL drop the req, set timeout_err, skip DONE so frame_count is not incremented, and go to IDLE.
REQ-027 A tick detected in any state other than IDLE SHALL set overrun and SHALL be discarded, with no queued sequence.
REQ-028 If a tick occurs in the same cycle the sequencer returns from DONE to IDLE, the tick SHALL count as an overrun.
REQ-029 move_req and draw_req SHALL never be high at the same time.
REQ-030 clear SHALL never be high outside CLEAR.
REQ-031 overrun and timeout_err SHALL clear only on reset.

Reset
REQ-032 On reset the sequencer SHALL immediately go to IDLE and hold all of the following at 0: the registered rclock, the wait counter, clear, move_req, draw_req, busy, overrun, timeout_err and frame_count.
REQ-033 If reset is asserted mid-sequence, all requests SHALL drop in the same instant, asynchronously, and an rclock that is already high when reset releases SHALL NOT produce a tick until it goes low and then high again.

Verification
REQ-034 Drive a rclock rising edge with move_ack returned 3 cycles after move_req and draw_ack 5 cycles after draw_req -> clear high 1 cycle after the edge, move_req 1 cycle after that, frame_count = 1, busy low after DONE.
REQ-035 Hold move_ack low with TIMEOUT = 16'd8 -> move_req drops after 8 wait cycles, timeout_err = 1, frame_count unchanged, state IDLE.
REQ-036 Apply a second rclock edge while draw_req is pending -> overrun = 1, only one sequence runs, frame_count incremented by 1.
REQ-037 Hold move_ack high continuously before the sequence starts -> move_req is high for exactly 1 cycle and the sequence proceeds to DRAW.
REQ-038 Preload frame_count to 16'hFFFF by running 65535 sequences (or by forcing the register) and complete one more sequence -> frame_count = 0.
REQ-039 Assert reset while draw_req is high, with rclock high -> all outputs 0 immediately; after release, no tick occurs until rclock goes low and then high again.
